// File: rtl/dec_digit_pkg.sv
// Shared definitions for the serial decimal-to-binary accumulator.
//   state_t     : FSM encoding (IDLE / ACC / DONE)
//   DEC_BASE    : radix of the incoming digit stream
//   DIGIT_MINUS : code that marks a leading minus sign (signed build only)
//   DIGIT_MAX   : largest legal BCD digit
package dec_digit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int         DEC_BASE    = 10;
  localparam logic [3:0] DIGIT_MINUS = 4'hA;
  localparam logic [3:0] DIGIT_MAX   = 4'd9;

endpackage

// File: rtl/mul10_add.sv
// Combinational step of the decimal accumulator: acc*10 + digit.
// The product is formed in W+4 bits, so it cannot wrap. The result is
// clamped to the supplied limit, and ovf is raised when clamping happens.
// Ports:
//   acc   in  W    current accumulated magnitude
//   digit in  4    incoming digit, already checked as legal by the caller
//   limit in  W    largest magnitude allowed for the current number
//   sum   out W    min(acc*10+digit, limit)
//   ovf   out 1    acc*10+digit exceeded limit
module mul10_add
  import dec_digit_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] acc,
  input  logic [3:0]   digit,
  input  logic [W-1:0] limit,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W+3:0] full;

  // acc*DEC_BASE is built from shifts, so no multiplier is needed
  always_comb begin
    full = ({4'b0000, acc} << 3) + ({4'b0000, acc} << 1) + {{W{1'b0}}, digit};
    ovf  = full > {4'b0000, limit};
    sum  = ovf ? limit : full[W-1:0];
  end

endmodule

// File: rtl/dec_digit_accum.sv
// Serial decimal-to-binary converter. BCD digits arrive one per d_valid/d_ready
// beat, most significant digit first, and update value = value*10 + digit.
// The beat flagged d_last ends the number. The binary result is then held on
// the o_valid/o_ready port until it is taken.
// Build option: define DEC_DIGIT_ACCUM_SIGN_EN to make a leading 4'hA a minus
// sign. The result is then two's complement with signed saturation.
// Ports:
//   clk      in   1   clock, rising edge
//   rst_b    in   1   asynchronous active-low reset
//   clr      in   1   synchronous clear, overrides every other input
//   d_valid  in   1   digit beat valid
//   d_ready  out  1   digit can be accepted (low while a result is pending)
//   digit    in   4   BCD digit
//   d_last   in   1   final digit of the number
//   o_valid  out  1   result valid, held until o_ready
//   o_ready  in   1   downstream takes the result
//   o_value  out  W   binary result
//   o_ndig   out  NW  digits accumulated into the number
//   o_err    out  1   sticky error: bad digit, overflow or too many digits
module dec_digit_accum
  import dec_digit_pkg::*;
#(
  parameter  int W          = 8,
  parameter  int MAX_DIGITS = 3,
  localparam int NW         = $clog2(MAX_DIGITS + 1)
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          clr,
  input  logic          d_valid,
  output logic          d_ready,
  input  logic [3:0]    digit,
  input  logic          d_last,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [W-1:0]  o_value,
  output logic [NW-1:0] o_ndig,
  output logic          o_err
);

  // state | meaning
  // IDLE  | waiting for the first beat of a number
  // ACC   | at least one beat taken, collecting digits
  // DONE  | result presented, waiting for o_ready

  state_t        state;
  logic [W-1:0]  acc;
  logic [NW-1:0] ndig;
  logic          err;

  logic          accept;
  logic [W-1:0]  limit;
  logic [W-1:0]  mul_sum;
  logic          mul_ovf;
  logic [W-1:0]  acc_nx;
  logic [NW-1:0] ndig_nx;
  logic          err_nx;
  logic [W-1:0]  val_nx;

  assign accept = d_valid && d_ready;
  assign o_ndig = ndig;
  assign o_err  = err;

`ifdef DEC_DIGIT_ACCUM_SIGN_EN
  logic neg;
  logic neg_nx;
  logic is_minus;

  // Only the first beat of a number can be a sign. Later 4'hA codes fall
  // through to the bad-digit check.
  assign is_minus = (state == IDLE) && (digit == DIGIT_MINUS);
  // A negative number may reach magnitude 2^(W-1), because -2^(W-1) is representable
  assign limit    = neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`else
  assign limit    = {W{1'b1}};
`endif

  mul10_add #(.W(W)) u_mul10_add (
    .acc   (acc),
    .digit (digit),
    .limit (limit),
    .sum   (mul_sum),
    .ovf   (mul_ovf)
  );

  // Next accumulator contents for an accepted beat
  always_comb begin
    acc_nx  = acc;
    ndig_nx = ndig;
    err_nx  = err;
`ifdef DEC_DIGIT_ACCUM_SIGN_EN
    neg_nx  = neg;
    if (is_minus) begin
      neg_nx = 1'b1;
      // A sign with no digits after it is not a number
      if (d_last) err_nx = 1'b1;
    end else
`endif
    if (digit > DIGIT_MAX) begin
      err_nx = 1'b1;
    end else if (ndig == NW'(MAX_DIGITS)) begin
      err_nx = 1'b1;
    end else begin
      acc_nx  = mul_sum;
      ndig_nx = ndig + NW'(1);
      if (mul_ovf) err_nx = 1'b1;
    end
    val_nx = acc_nx;
`ifdef DEC_DIGIT_ACCUM_SIGN_EN
    if (neg_nx) val_nx = ~acc_nx + W'(1);
`endif
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state   <= IDLE;
      acc     <= '0;
      ndig    <= '0;
      err     <= 1'b0;
      o_valid <= 1'b0;
      o_value <= '0;
      d_ready <= 1'b1;
`ifdef DEC_DIGIT_ACCUM_SIGN_EN
      neg     <= 1'b0;
`endif
    end else if (clr) begin
      state   <= IDLE;
      acc     <= '0;
      ndig    <= '0;
      err     <= 1'b0;
      o_valid <= 1'b0;
      o_value <= '0;
      d_ready <= 1'b1;
`ifdef DEC_DIGIT_ACCUM_SIGN_EN
      neg     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, ACC: begin
          if (accept) begin
            acc  <= acc_nx;
            ndig <= ndig_nx;
            err  <= err_nx;
`ifdef DEC_DIGIT_ACCUM_SIGN_EN
            neg  <= neg_nx;
`endif
            if (d_last) begin
              state   <= DONE;
              o_valid <= 1'b1;
              o_value <= val_nx;
              d_ready <= 1'b0;
            end else begin
              state <= ACC;
            end
          end
        end
        DONE: begin
          // d_ready stays low through the handshake cycle. Intake restarts next cycle.
          if (o_ready) begin
            state   <= IDLE;
            acc     <= '0;
            ndig    <= '0;
            err     <= 1'b0;
            o_valid <= 1'b0;
            o_value <= '0;
            d_ready <= 1'b1;
`ifdef DEC_DIGIT_ACCUM_SIGN_EN
            neg     <= 1'b0;
`endif
          end
        end
        default: begin
          state   <= IDLE;
          d_ready <= 1'b1;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
